stoplight_guard: RTL and testbench
==================================

# stoplight_guard

Safety monitor and lamp driver sitting directly downstream of the stoplight sequencer. It samples the six sequencer light outputs every clock and passes them to the lamp drivers with one cycle of latency while checking three things: the two directions never conflict, each direction steps only through legal colour transitions, and the lights keep changing. On any violation it latches a fault, never shows the offending pattern, and drives both red lamps flashing until software clears the fault.

## Interface
- STARTUP, 4: cycles both reds are held solid after reset or fault clear before pass-through begins (≥1).
- MAX_HOLD, 32: maximum consecutive cycles with no colour change on either direction before a watchdog fault (≥2).
- FLASH_HALF, 2: cycles per on/off half-period of the fault flash (≥1).

- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ns_red_in, ns_yellow_in, ns_green_in  in  1 each  northsouth lights from sequencer
- ew_red_in, ew_yellow_in, ew_green_in  in  1 each  eastwest lights from sequencer
- clear_fault  in  1  synchronous single-cycle pulse; leaves fault state
- ns_red, ns_yellow, ns_green  out  1 each  registered northsouth lamp drives
- ew_red, ew_yellow, ew_green  out  1 each  registered eastwest lamp drives
- fault  out  1  registered, sticky fault flag
- fault_code  out  2  0 none, 1 conflict, 2 illegal sequence, 3 watchdog

## Operation
- States: INIT, PASS, FLASH. Reset → INIT.
- Reset values: ns_red=1, ew_red=1, all yellow/green=0, fault=0, fault_code=0, all counters 0.
- INIT: both reds solid, yellows/greens 0, inputs ignored; startup counter counts STARTUP cycles, then PASS. No checks in INIT.
- PASS: each edge, current inputs are checked combinationally; if legal, lamps <= inputs and prev colour registers <= inputs.
- Colour of a direction = one-hot {R,Y,G}; anything else (0 or >1 bits) is a conflict.
- Conflict: either direction not one-hot, or both directions non-red in the same sample.
- Illegal sequence: per direction legal moves are hold, R→G, G→Y, Y→R; anything else (e.g. G→R, R→Y, Y→G) faults. Skipped on the first PASS sample (no valid prev).
- Watchdog: hold counter, width clog2(MAX_HOLD+1), clears on any colour change in either direction (and on PASS entry), else increments; a sample that would bring it to MAX_HOLD faults.
- Priority when several hold in one sample: conflict > sequence > watchdog.
- On fault: at that same edge go to FLASH, fault<=1, fault_code<=cause, both reds <=1 (on phase), yellows/greens <=0. Offending pattern never reaches lamps.
- FLASH: flash counter toggles both reds together every FLASH_HALF cycles (first on-phase lasts FLASH_HALF cycles); yellows/greens 0; inputs ignored; fault/fault_code hold.
- clear_fault in FLASH: next edge → INIT, fault<=0, fault_code<=0, both reds solid, counters cleared. clear_fault in INIT/PASS: ignored.
- reset_n low at any time: immediate return to reset values, any fault discarded.

## Timing
- Pass-through latency: input sampled at edge k appears on lamps after edge k (1 cycle).
- Fault indication latency: fault/fault_code valid after the same edge that samples the violation.
- INIT lasts exactly STARTUP cycles; first input sample passed is the one at edge STARTUP+1 after reset release.
- Flash period 2·FLASH_HALF cycles, 50% duty.
- clear_fault to INIT: 1 cycle; INIT to PASS: STARTUP cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then drive legal sequencer cycle (NS G 11 cycles, NS Y 4, EW G 7, EW Y 4, repeat) for 3 rounds -> both reds for 4 cycles, then lamps equal inputs delayed 1 cycle, fault stays 0.
- In PASS drive ns_green=1 and ew_green=1 for one cycle -> after that edge fault=1, code=1, both reds 1, greens 0; reds toggle every 2 cycles.
- Drive NS G directly to NS R (skipping Y) -> fault=1, code=2; drive the same on the first PASS sample only -> no fault.
- Hold NS G/EW R constant for 32 samples -> fault=1, code=3 on the 32nd; 31 constant samples then change -> no fault.
- From FLASH pulse clear_fault -> next cycle fault=0, code=0, reds solid 4 cycles, then pass-through resumes; clear_fault in PASS has no effect.
- Assert reset_n low mid-FLASH and mid-PASS -> outputs return to reset values asynchronously, fault=0.

Source files
------------

// File: rtl/stoplight_guard.sv
// Lamp driver and safety monitor behind the stoplight sequencer.
// Passes lights through with one cycle of latency and flashes both reds on any fault.
module stoplight_guard #(
    parameter int STARTUP    = 4,
    parameter int MAX_HOLD   = 32,
    parameter int FLASH_HALF = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_red_in,
    input  logic       ns_yellow_in,
    input  logic       ns_green_in,
    input  logic       ew_red_in,
    input  logic       ew_yellow_in,
    input  logic       ew_green_in,
    input  logic       clear_fault,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int SW = $clog2(STARTUP + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_CONF = 2'd1;
    localparam logic [1:0] C_SEQ  = 2'd2;
    localparam logic [1:0] C_WD   = 2'd3;

    typedef enum logic [1:0] {
        S_INIT,
        S_PASS,
        S_FLASH
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   start_cnt, start_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [FW-1:0]   flash_cnt, flash_nxt;
    logic            first_q, first_nxt;
    logic [2:0]      prev_ns, prev_ns_nxt;
    logic [2:0]      prev_ew, prev_ew_nxt;
    logic [2:0]      ns_q, ns_nxt;
    logic [2:0]      ew_q, ew_nxt;
    logic            fault_q, fault_nxt;
    logic [1:0]      code_q, code_nxt;

    logic [2:0]      ns_c, ew_c;
    logic            conflict, seq_bad, wd_bad, changed;
    logic            start_done, flash_done;
    logic [HW-1:0]   hold_inc;
    logic [1:0]      cause;

    function automatic logic step_ok(input logic [2:0] p,
                                     input logic [2:0] c);
        return (c == p) ||
               (p == RED && c == GRN) ||
               (p == GRN && c == YEL) ||
               (p == YEL && c == RED);
    endfunction

    assign ns_c = {ns_red_in, ns_yellow_in, ns_green_in};
    assign ew_c = {ew_red_in, ew_yellow_in, ew_green_in};

    assign conflict = !$onehot(ns_c) || !$onehot(ew_c) ||
                      (!ns_c[2] && !ew_c[2]);
    assign seq_bad  = !first_q &&
                      (!step_ok(prev_ns, ns_c) || !step_ok(prev_ew, ew_c));
    assign changed  = (ns_c != prev_ns) || (ew_c != prev_ew);
    assign hold_inc = hold_cnt + HW'(1);
    // The first sample after INIT has no history, so it can't stall either.
    assign wd_bad   = !first_q && !changed && (hold_inc == HW'(MAX_HOLD));

    always_comb begin
        cause = C_NONE;
        if (conflict)
            cause = C_CONF;
        else if (seq_bad)
            cause = C_SEQ;
        else if (wd_bad)
            cause = C_WD;
    end

    assign start_done = (start_cnt == SW'(STARTUP - 1));
    assign flash_done = (flash_cnt == FW'(FLASH_HALF - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_INIT;
            start_cnt <= '0;
            hold_cnt  <= '0;
            flash_cnt <= '0;
            first_q   <= 1'b0;
            prev_ns   <= RED;
            prev_ew   <= RED;
            ns_q      <= RED;
            ew_q      <= RED;
            fault_q   <= 1'b0;
            code_q    <= C_NONE;
        end else begin
            state     <= state_nxt;
            start_cnt <= start_nxt;
            hold_cnt  <= hold_nxt;
            flash_cnt <= flash_nxt;
            first_q   <= first_nxt;
            prev_ns   <= prev_ns_nxt;
            prev_ew   <= prev_ew_nxt;
            ns_q      <= ns_nxt;
            ew_q      <= ew_nxt;
            fault_q   <= fault_nxt;
            code_q    <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:  if (start_done) state_nxt = S_PASS;
            S_PASS:  if (cause != C_NONE) state_nxt = S_FLASH;
            S_FLASH: if (clear_fault) state_nxt = S_INIT;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        start_nxt   = start_cnt;
        hold_nxt    = hold_cnt;
        flash_nxt   = flash_cnt;
        first_nxt   = first_q;
        prev_ns_nxt = prev_ns;
        prev_ew_nxt = prev_ew;
        ns_nxt      = ns_q;
        ew_nxt      = ew_q;
        fault_nxt   = fault_q;
        code_nxt    = code_q;
        unique case (state)
            S_INIT: begin
                ns_nxt    = RED;
                ew_nxt    = RED;
                start_nxt = start_cnt + SW'(1);
                if (start_done) begin
                    start_nxt = '0;
                    hold_nxt  = '0;
                    first_nxt = 1'b1;
                end
            end
            S_PASS: begin
                if (cause != C_NONE) begin
                    ns_nxt    = RED;
                    ew_nxt    = RED;
                    fault_nxt = 1'b1;
                    code_nxt  = cause;
                    flash_nxt = '0;
                end else begin
                    ns_nxt      = ns_c;
                    ew_nxt      = ew_c;
                    prev_ns_nxt = ns_c;
                    prev_ew_nxt = ew_c;
                    first_nxt   = 1'b0;
                    hold_nxt    = (first_q || changed) ? '0 : hold_inc;
                end
            end
            S_FLASH: begin
                if (clear_fault) begin
                    ns_nxt    = RED;
                    ew_nxt    = RED;
                    fault_nxt = 1'b0;
                    code_nxt  = C_NONE;
                    start_nxt = '0;
                    hold_nxt  = '0;
                    flash_nxt = '0;
                end else if (flash_done) begin
                    // Both reds share one phase; ns_q[2] is the master copy.
                    flash_nxt = '0;
                    ns_nxt    = {~ns_q[2], 2'b00};
                    ew_nxt    = {~ns_q[2], 2'b00};
                end else begin
                    flash_nxt = flash_cnt + FW'(1);
                    ns_nxt    = {ns_q[2], 2'b00};
                    ew_nxt    = {ns_q[2], 2'b00};
                end
            end
            default: ;
        endcase
    end

    assign {ns_red, ns_yellow, ns_green} = ns_q;
    assign {ew_red, ew_yellow, ew_green} = ew_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_stoplight_guard.sv
// Scoreboard bench for stoplight_guard: expectations are queued as stimulus
// is driven and checked one cycle later after the clock edge.
module tb_stoplight_guard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ns_red_in, ns_yellow_in, ns_green_in;
    logic       ew_red_in, ew_yellow_in, ew_green_in;
    logic       clear_fault;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       fault;
    logic [1:0] fault_code;
    logic [5:0] lamps;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int FH = 2;

    typedef struct packed {
        logic [5:0] lamps;
        logic       flt;
        logic [1:0] code;
    } exp_t;

    exp_t  sb[$];
    exp_t  cur;
    int    n_chk = 0;
    int    n_bad = 0;
    string phase = "reset";

    stoplight_guard #(
        .STARTUP(4),
        .MAX_HOLD(32),
        .FLASH_HALF(FH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ns_red_in(ns_red_in),
        .ns_yellow_in(ns_yellow_in),
        .ns_green_in(ns_green_in),
        .ew_red_in(ew_red_in),
        .ew_yellow_in(ew_yellow_in),
        .ew_green_in(ew_green_in),
        .clear_fault(clear_fault),
        .ns_red(ns_red),
        .ns_yellow(ns_yellow),
        .ns_green(ns_green),
        .ew_red(ew_red),
        .ew_yellow(ew_yellow),
        .ew_green(ew_green),
        .fault(fault),
        .fault_code(fault_code)
    );

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h want %0h", phase, tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("lamps", int'(lamps), int'(cur.lamps));
            chk("fault", int'(fault), int'(cur.flt));
            chk("code", int'(fault_code), int'(cur.code));
        end
    end

    // Called at a negedge; returns at the next negedge after the check.
    task automatic step(input logic [2:0] ns, input logic [2:0] ew,
                        input logic clr, input logic [5:0] el,
                        input logic ef, input logic [1:0] ec);
        {ns_red_in, ns_yellow_in, ns_green_in} = ns;
        {ew_red_in, ew_yellow_in, ew_green_in} = ew;
        clear_fault = clr;
        sb.push_back(exp_t'({el, ef, ec}));
        @(negedge clk);
    endtask

    task automatic init_steps(input logic [2:0] ns, input logic [2:0] ew);
        repeat (4) step(ns, ew, 1'b0, {R, R}, 1'b0, 2'd0);
    endtask

    task automatic flash_steps(input int n, input logic [1:0] c);
        for (int k = 1; k <= n; k++)
            step(G, Y, 1'b0, (((k / FH) % 2) == 0) ? {R, R} : 6'b0, 1'b1, c);
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset_n = 1'b0;
        #1;
        phase = tag;
        chk("lamps", int'(lamps), int'({R, R}));
        chk("fault", int'(fault), 0);
        chk("code", int'(fault_code), 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        {ns_red_in, ns_yellow_in, ns_green_in} = 3'b000;
        {ew_red_in, ew_yellow_in, ew_green_in} = 3'b000;
        clear_fault = 1'b0;
        @(negedge clk);
        chk("lamps", int'(lamps), int'({R, R}));
        chk("fault", int'(fault), 0);
        chk("code", int'(fault_code), 0);
        reset_n = 1'b1;

        phase = "init";
        init_steps(G, G);

        phase = "legal";
        for (int r = 0; r < 3; r++) begin
            repeat (11) step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
            repeat (4)  step(Y, R, 1'b0, {Y, R}, 1'b0, 2'd0);
            repeat (7)  step(R, G, 1'b0, {R, G}, 1'b0, 2'd0);
            repeat (4)  step(R, Y, 1'b0, {R, Y}, 1'b0, 2'd0);
        end

        // Also an illegal EW Y->G move: conflict must win.
        phase = "conflict";
        step(G, G, 1'b0, {R, R}, 1'b1, 2'd1);
        flash_steps(6, 2'd1);

        phase = "clear";
        step(G, G, 1'b1, {R, R}, 1'b0, 2'd0);
        init_steps(G, R);

        phase = "first_sample";
        step(R, R, 1'b0, {R, R}, 1'b0, 2'd0);

        phase = "seq";
        step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
        step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
        step(R, R, 1'b0, {R, R}, 1'b1, 2'd2);
        flash_steps(3, 2'd2);
        step(R, R, 1'b1, {R, R}, 1'b0, 2'd0);
        init_steps(R, R);

        phase = "wd31";
        step(R, R, 1'b0, {R, R}, 1'b0, 2'd0);
        step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
        for (int i = 0; i < 31; i++)
            step(G, R, (i == 5), {G, R}, 1'b0, 2'd0);
        step(Y, R, 1'b0, {Y, R}, 1'b0, 2'd0);
        step(R, R, 1'b0, {R, R}, 1'b0, 2'd0);
        step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);

        phase = "wd32";
        repeat (31) step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
        step(G, R, 1'b0, {R, R}, 1'b1, 2'd3);
        flash_steps(2, 2'd3);

        async_reset_check("rst_flash");
        phase = "post_rst";
        init_steps(G, R);
        repeat (3) step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);

        async_reset_check("rst_pass");
        phase = "post_rst2";
        init_steps(Y, Y);
        step(G, R, 1'b0, {G, R}, 1'b0, 2'd0);
        step(Y, R, 1'b0, {Y, R}, 1'b0, 2'd0);

        phase = "end";
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
